cam_capture_ctrl: RTL and testbench

- Sequences the camera-to-framebuffer path: samples OV7670 byte stream (VSYNC/HREF/DATA), pairs bytes into 16-bit RGB565 words for the RGB565→RGB332 downsampler, and generates framebuffer write strobe plus X/Y address.
- Sits between camera pins (CLK driven by camera PCLK) and the downsampler/framebuffer RAM write port; handles arming, frame sync, cropping and byte ordering.

---
 rtl/cam_capture_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cam_capture_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_ctrl.sv
// OV7670 capture sequencer: pairs camera bytes into RGB565 words and
// issues framebuffer writes with X/Y addressing, cropping and frame sync.
module cam_capture_ctrl #(
  parameter int IMG_W     = 176,
  parameter int IMG_H     = 144,
  parameter int X_BITS    = 8,
  parameter int Y_BITS    = 8,
  parameter int BYTE_SWAP = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              MODE_CONT,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic [7:0]        DATA,
  output logic [15:0]       PIXEL565,
  output logic              W_EN,
  output logic [X_BITS-1:0] WRITE_X,
  output logic [Y_BITS-1:0] WRITE_Y,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic              SHORT_LINE
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FRAME
  } state_t;

  localparam logic [X_BITS-1:0] XW = X_BITS'(IMG_W);
  localparam logic [Y_BITS-1:0] YH = Y_BITS'(IMG_H);

  state_t            state_q, state_d;
  logic              vs_q, vs_d;
  logic              hr_q, hr_d;
  logic              phase_q, phase_d;
  logic [7:0]        first_q, first_d;
  logic [X_BITS-1:0] x_q, x_d;
  logic [Y_BITS-1:0] y_q, y_d;
  logic              wen_q, wen_d;
  logic [15:0]       pix_q, pix_d;
  logic [X_BITS-1:0] wx_q, wx_d;
  logic [Y_BITS-1:0] wy_q, wy_d;
  logic              done_q, done_d;
  logic              short_q, short_d;

  logic              vs_fall, vs_rise, hr_fall;
  logic              in_win;
  logic [15:0]       pair;

  assign vs_fall = vs_q & ~VSYNC;
  assign vs_rise = ~vs_q & VSYNC;
  assign hr_fall = hr_q & ~HREF;
  assign in_win  = (x_q < XW) && (y_q < YH);
  assign pair    = (BYTE_SWAP != 0) ? {DATA, first_q}
                                    : {first_q, DATA};

  always_comb begin
    state_d = state_q;
    vs_d    = VSYNC;
    hr_d    = HREF;
    phase_d = phase_q;
    first_d = first_q;
    x_d     = x_q;
    y_d     = y_q;
    wen_d   = 1'b0;
    pix_d   = pix_q;
    wx_d    = wx_q;
    wy_d    = wy_q;
    done_d  = 1'b0;
    short_d = short_q;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_WAIT;
          short_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (vs_fall) begin
          state_d = S_FRAME;
          x_d     = '0;
          y_d     = '0;
          phase_d = 1'b0;
        end
      end
      S_FRAME: begin
        if (HREF) begin
          if (!phase_q) begin
            first_d = DATA;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (in_win) begin
              wen_d = 1'b1;
              pix_d = pair;
              wx_d  = x_q;
              wy_d  = y_q;
            end
            if (x_q < XW) x_d = x_q + 1'b1;
          end
        end
        // an empty line (no complete pixel) leaves Y untouched
        if (hr_fall) begin
          if (x_q != '0) begin
            if (y_q < YH) y_d = y_q + 1'b1;
            if (in_win) short_d = 1'b1;
          end
          x_d     = '0;
          phase_d = 1'b0;
        end
        if (vs_rise) begin
          done_d  = 1'b1;
          state_d = MODE_CONT ? S_WAIT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      vs_q    <= 1'b0;
      hr_q    <= 1'b0;
      phase_q <= 1'b0;
      first_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      wen_q   <= 1'b0;
      pix_q   <= '0;
      wx_q    <= '0;
      wy_q    <= '0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_q    <= vs_d;
      hr_q    <= hr_d;
      phase_q <= phase_d;
      first_q <= first_d;
      x_q     <= x_d;
      y_q     <= y_d;
      wen_q   <= wen_d;
      pix_q   <= pix_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      done_q  <= done_d;
      short_q <= short_d;
    end
  end

  assign PIXEL565   = pix_q;
  assign W_EN       = wen_q;
  assign WRITE_X    = wx_q;
  assign WRITE_Y    = wy_q;
  assign BUSY       = (state_q != S_IDLE);
  assign FRAME_DONE = done_q;
  assign SHORT_LINE = short_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench: a small-window DUT (4x2, normal byte order) and a
// default-size DUT with swapped byte order share one camera stimulus.
module tb_cam_capture_ctrl;

  logic       clk = 1'b0;
  logic       RESET, START, MODE_CONT, VSYNC, HREF;
  logic [7:0] DATA;

  logic [15:0] pix_a, pix_b;
  logic        wen_a, wen_b;
  logic [7:0]  wx_a, wy_a, wx_b, wy_b;
  logic        busy_a, busy_b, fd_a, fd_b, short_a, short_b;

  int vectors = 0;
  int miscompares = 0;
  int nwr_a = 0;
  int nwr_b = 0;
  int nfd_a = 0;
  int c0, cb, f0;

  always #5 clk = ~clk;

  cam_capture_ctrl #(
    .IMG_W(4), .IMG_H(2), .X_BITS(8), .Y_BITS(8), .BYTE_SWAP(0)
  ) dut_a (
    .CLK(clk), .RESET(RESET), .START(START), .MODE_CONT(MODE_CONT),
    .VSYNC(VSYNC), .HREF(HREF), .DATA(DATA),
    .PIXEL565(pix_a), .W_EN(wen_a), .WRITE_X(wx_a), .WRITE_Y(wy_a),
    .BUSY(busy_a), .FRAME_DONE(fd_a), .SHORT_LINE(short_a)
  );

  cam_capture_ctrl #(
    .BYTE_SWAP(1)
  ) dut_b (
    .CLK(clk), .RESET(RESET), .START(START), .MODE_CONT(MODE_CONT),
    .VSYNC(VSYNC), .HREF(HREF), .DATA(DATA),
    .PIXEL565(pix_b), .W_EN(wen_b), .WRITE_X(wx_b), .WRITE_Y(wy_b),
    .BUSY(busy_b), .FRAME_DONE(fd_b), .SHORT_LINE(short_b)
  );

  always @(negedge clk) begin
    if (wen_a) nwr_a++;
    if (wen_b) nwr_b++;
    if (fd_a)  nfd_a++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb(input logic [7:0] b);
    HREF = 1'b1;
    DATA = b;
    tick();
  endtask

  task automatic lend();
    HREF = 1'b0;
    tick();
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; MODE_CONT = 1'b0;
    VSYNC = 1'b1; HREF = 1'b0; DATA = 8'h00;
    tick(); tick();
    RESET = 1'b0;
    chk("rst_wen", wen_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_pix", pix_a, 0);
    chk("rst_x", wx_a, 0);
    chk("rst_done", fd_a, 0);
    chk("rst_short", short_a, 0);

    START = 1'b1; tick(); START = 1'b0;
    chk("arm_busy", busy_a, 1);
    VSYNC = 1'b0; tick();
    chk("frame_busy", busy_a, 1);
    tick();

    sb(8'hF8);
    chk("b1_wen", wen_a, 0);
    sb(8'h00);
    chk("p0_wen", wen_a, 1);
    chk("p0_pix", pix_a, 16'hF800);
    chk("p0_x", wx_a, 0);
    chk("p0_y", wy_a, 0);
    chk("p0_swap_pix", pix_b, 16'h00F8);
    sb(8'h07);
    chk("p1_gap_wen", wen_a, 0);
    chk("p1_gap_hold", pix_a, 16'hF800);
    sb(8'hE0);
    chk("p1_wen", wen_a, 1);
    chk("p1_pix", pix_a, 16'h07E0);
    chk("p1_x", wx_a, 1);
    chk("p1_y", wy_a, 0);
    sb(8'h1F); sb(8'h00);
    chk("p2_pix", pix_a, 16'h1F00);
    chk("p2_swap_pix", pix_b, 16'h001F);
    chk("p2_x", wx_a, 2);
    sb(8'hFF); sb(8'hFF);
    chk("p3_x", wx_a, 3);
    chk("p3_pix", pix_a, 16'hFFFF);
    lend();
    chk("l0_short_full", short_a, 0);
    chk("l0_short_b", short_b, 1);
    tick();

    c0 = nwr_a;
    sb(8'h01); sb(8'h02);
    chk("l1_first_x", wx_a, 0);
    chk("l1_first_y", wy_a, 1);
    chk("l1_first_pix", pix_a, 16'h0102);
    for (int i = 0; i < 10; i++) sb(8'(8'h10 + i));
    lend();
    chk("l1_crop_cnt", nwr_a - c0, 4);
    chk("l1_last_x", wx_a, 3);
    chk("l1_last_y", wy_a, 1);
    chk("l1_short", short_a, 0);
    tick();

    c0 = nwr_a;
    cb = nwr_b;
    for (int i = 0; i < 4; i++) sb(8'(8'h20 + i));
    lend();
    chk("l2_ycrop_cnt", nwr_a - c0, 0);
    chk("l2_b_cnt", nwr_b - cb, 2);
    chk("l2_b_y", wy_b, 2);

    VSYNC = 1'b1; tick();
    chk("f0_done", fd_a, 1);
    chk("f0_idle", busy_a, 0);
    tick();
    chk("f0_done_pulse", fd_a, 0);

    START = 1'b1; tick(); START = 1'b0;
    chk("sl_clr_a", short_a, 0);
    chk("sl_clr_b", short_b, 0);
    VSYNC = 1'b0; tick(); tick();
    c0 = nwr_a;
    for (int i = 0; i < 5; i++) sb(8'(8'h30 + i));
    lend();
    chk("sl_cnt", nwr_a - c0, 2);
    chk("sl_set", short_a, 1);
    chk("sl_last_x", wx_a, 1);

    MODE_CONT = 1'b1;
    f0 = nfd_a;
    VSYNC = 1'b1; tick();
    chk("mc_busy", busy_a, 1);
    tick();
    VSYNC = 1'b0; tick();
    START = 1'b1; tick(); START = 1'b0;
    chk("start_ignored", short_a, 1);
    sb(8'hAA); sb(8'h55);
    chk("f2_wen", wen_a, 1);
    chk("f2_x", wx_a, 0);
    chk("f2_y", wy_a, 0);
    chk("f2_pix", pix_a, 16'hAA55);
    lend();
    VSYNC = 1'b1; tick(); tick();
    chk("mc_done_cnt", nfd_a - f0, 2);
    chk("mc_rearm", busy_a, 1);

    VSYNC = 1'b0; tick();
    sb(8'h12); sb(8'h34);
    chk("pre_rst_wen", wen_a, 1);
    RESET = 1'b1; HREF = 1'b1; DATA = 8'h56; VSYNC = 1'b1;
    f0 = nfd_a;
    tick();
    chk("mrst_wen", wen_a, 0);
    chk("mrst_pix", pix_a, 0);
    chk("mrst_x", wx_a, 0);
    chk("mrst_busy", busy_a, 0);
    chk("mrst_done", fd_a, 0);
    RESET = 1'b0; HREF = 1'b0;
    tick();
    chk("mrst_done_cnt", nfd_a - f0, 0);

    MODE_CONT = 1'b0;
    VSYNC = 1'b0; tick();
    START = 1'b1; tick(); START = 1'b0;
    chk("am_busy", busy_a, 1);
    c0 = nwr_a;
    f0 = nfd_a;
    for (int i = 0; i < 4; i++) sb(8'(8'h40 + i));
    lend();
    chk("am_no_wr", nwr_a - c0, 0);
    VSYNC = 1'b1; tick(); tick();
    chk("am_no_done", nfd_a - f0, 0);
    VSYNC = 1'b0; tick();
    sb(8'hBE); sb(8'hEF);
    chk("am_wen", wen_a, 1);
    chk("am_x", wx_a, 0);
    chk("am_y", wy_a, 0);
    chk("am_pix", pix_a, 16'hBEEF);
    lend();
    VSYNC = 1'b1; tick();
    chk("am_done", fd_a, 1);
    chk("am_idle", busy_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
